// File: rtl/array_pkg.sv
// Shared types and default sizing for the array access controller and its attached array.
package array_pkg;

    localparam int ARR_WIDTH    = 8;
    localparam int ARR_DEPTH    = 2048;
    localparam int ARR_MAXBURST = 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_CAP,
        RD_HOLD
    } arr_state_t;

endpackage : array_pkg

// File: rtl/array_access_ctrl_if.sv
// Requester-side bundle: burst request, write-data stream, read-data stream and busy.
interface array_access_ctrl_if
    import array_pkg::*;
#(
    parameter int WIDTH    = ARR_WIDTH,
    parameter int DEPTH    = ARR_DEPTH,
    parameter int MAXBURST = ARR_MAXBURST
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(MAXBURST);

    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [AW-1:0]    req_addr;
    logic [LW-1:0]    req_len;

    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;

    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;

    logic             busy;

    modport master (
        output req_valid, req_write, req_addr, req_len,
        output wr_valid, wr_data,
        output rd_ready,
        input  req_ready, wr_ready, rd_valid, rd_data, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_len,
        input  wr_valid, wr_data,
        input  rd_ready,
        output req_ready, wr_ready, rd_valid, rd_data, busy
    );

endinterface : array_access_ctrl_if

// File: rtl/array_access_ctrl.sv
// Burst controller turning request/stream handshakes into single-word accesses on a
// registered-read array port: one write per cycle, one read per three cycles.
module array_access_ctrl
    import array_pkg::*;
#(
    parameter int WIDTH    = ARR_WIDTH,
    parameter int DEPTH    = ARR_DEPTH,
    parameter int MAXBURST = ARR_MAXBURST,
    localparam int AW      = $clog2(DEPTH),
    localparam int LW      = $clog2(MAXBURST)
) (
    input  logic                clk,
    input  logic                rst,
    array_access_ctrl_if.slave  bus,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_rd_o_wr,
    output logic [WIDTH-1:0]    mem_i_data,
    input  logic [WIDTH-1:0]    mem_o_data
);

    arr_state_t       state, state_next;
    logic [AW-1:0]    cur_addr;
    logic [LW-1:0]    beats_left;
    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_data_q;

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.busy     = (state != IDLE);

    // cur_addr is exactly AW bits wide, so DEPTH-1 wraps to 0 for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_addr   <= '0;
            beats_left <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cur_addr   <= bus.req_addr;
                        beats_left <= bus.req_len;
                    end
                end
                WR: begin
                    if (bus.wr_valid) begin
                        cur_addr <= cur_addr + 1'b1;
                        if (beats_left != '0) beats_left <= beats_left - 1'b1;
                    end
                end
                RD_ISSUE: ;
                RD_CAP: begin
                    rd_data_q  <= mem_o_data;
                    rd_valid_q <= 1'b1;
                end
                RD_HOLD: begin
                    if (bus.rd_ready) begin
                        rd_valid_q <= 1'b0;
                        cur_addr   <= cur_addr + 1'b1;
                        if (beats_left != '0) beats_left <= beats_left - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_next    = state;
        bus.req_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        mem_rd_o_wr   = 1'b0;
        mem_addr      = cur_addr;
        mem_i_data    = bus.wr_data;

        // Reset overrides the handshakes so nothing is accepted or written while rst is high.
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    bus.req_ready = 1'b1;
                    if (bus.req_valid) state_next = bus.req_write ? WR : RD_ISSUE;
                end
                WR: begin
                    bus.wr_ready = 1'b1;
                    mem_rd_o_wr  = bus.wr_valid;
                    if (bus.wr_valid && beats_left == '0) state_next = IDLE;
                end
                RD_ISSUE: state_next = RD_CAP;
                RD_CAP:   state_next = RD_HOLD;
                RD_HOLD: begin
                    if (bus.rd_ready) state_next = (beats_left == '0) ? IDLE : RD_ISSUE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule : array_access_ctrl

// File: tb/tb_array_access_ctrl.sv
// Directed bench: controller paired with a behavioural registered-read array model.
module tb_array_access_ctrl;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 2048;
    localparam int MAXBURST = 8;
    localparam int AW       = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic [AW-1:0]    mem_addr;
    logic             mem_rd_o_wr;
    logic [WIDTH-1:0] mem_i_data;
    logic [WIDTH-1:0] mem_o_data;
    logic [WIDTH-1:0] mem [DEPTH];

    int errors = 0;
    int checks = 0;

    array_access_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAXBURST(MAXBURST)) bus ();

    array_access_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAXBURST(MAXBURST)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .mem_addr    (mem_addr),
        .mem_rd_o_wr (mem_rd_o_wr),
        .mem_i_data  (mem_i_data),
        .mem_o_data  (mem_o_data)
    );

    always #5 clk = ~clk;

    // Array model: synchronous write, registered read of the presented address.
    always @(posedge clk) begin
        if (mem_rd_o_wr) mem[mem_addr] <= mem_i_data;
        mem_o_data <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 11'h000;
        bus.req_len   = 3'd0;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 8'h5A;
        bus.rd_ready  = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", bus.req_ready); end
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got=%b exp=0", bus.wr_ready); end
        checks++; if (mem_rd_o_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got=%b exp=0", mem_rd_o_wr); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data); end
        checks++; if (mem_addr !== 11'h000) begin errors++; $display("FAIL reset_cur_addr got=%h exp=000", mem_addr); end
        bus.req_valid = 1'b0;
        bus.wr_valid  = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready got=%b exp=1", bus.req_ready); end
        checks++; if (mem[0] !== 8'h00) begin errors++; $display("FAIL reset_no_write got=%h exp=00", mem[0]); end
        tick();
    endtask

    task automatic write_burst(input logic [AW-1:0] addr, input logic [2:0] len, input logic [7:0] d0);
        logic [AW-1:0] a;
        logic [7:0]    d;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = addr;
        bus.req_len   = len;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL wr_req_ready got=%b exp=1", bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        bus.wr_valid  = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 11'(i);
            d = d0 + 8'(i);
            bus.wr_data = d;
            @(negedge clk);
            checks++; if (mem_rd_o_wr !== 1'b1 || bus.wr_ready !== 1'b1) begin errors++; $display("FAIL wr_beat%0d_strobe got=%b/%b exp=1/1", i, mem_rd_o_wr, bus.wr_ready); end
            checks++; if (mem_addr !== a) begin errors++; $display("FAIL wr_beat%0d_addr got=%h exp=%h", i, mem_addr, a); end
            checks++; if (mem_i_data !== d) begin errors++; $display("FAIL wr_beat%0d_data got=%h exp=%h", i, mem_i_data, d); end
            tick();
        end
        bus.wr_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL wr_end_idle busy/req_ready got=%b/%b exp=0/1", bus.busy, bus.req_ready); end
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 11'(i);
            d = d0 + 8'(i);
            checks++; if (mem[a] !== d) begin errors++; $display("FAIL wr_array[%h] got=%h exp=%h", a, mem[a], d); end
        end
        tick();
    endtask

    task automatic read_burst(input logic [AW-1:0] addr, input logic [2:0] len, input logic [7:0] d0,
                              input int stall);
        logic [AW-1:0] a;
        logic [7:0]    d;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = addr;
        bus.req_len   = len;
        bus.rd_ready  = (stall == 0);
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rd_req_ready got=%b exp=1", bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 11'(i);
            d = d0 + 8'(i);
            @(negedge clk);
            checks++; if (bus.rd_valid !== 1'b0 || mem_rd_o_wr !== 1'b0 || mem_addr !== a) begin
                errors++; $display("FAIL rd_beat%0d_issue valid/wr/addr got=%b/%b/%h exp=0/0/%h", i, bus.rd_valid, mem_rd_o_wr, mem_addr, a);
            end
            tick();
            @(negedge clk);
            checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rd_beat%0d_cap_valid got=%b exp=0", i, bus.rd_valid); end
            tick();
            if (i == 0) begin
                for (int k = 0; k < stall; k++) begin
                    @(negedge clk);
                    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== d || mem_addr !== a) begin
                        errors++; $display("FAIL rd_stall%0d valid/data/addr got=%b/%h/%h exp=1/%h/%h", k, bus.rd_valid, bus.rd_data, mem_addr, d, a);
                    end
                    tick();
                end
                bus.rd_ready = 1'b1;
            end
            @(negedge clk);
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== d) begin
                errors++; $display("FAIL rd_beat%0d valid/data got=%b/%h exp=1/%h", i, bus.rd_valid, bus.rd_data, d);
            end
            tick();
        end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rd_end busy/rd_valid got=%b/%b exp=0/0", bus.busy, bus.rd_valid); end
        tick();
    endtask

    task automatic test_wr_rd_basic();
        write_burst(11'h010, 3'd3, 8'hA1);
        read_burst(11'h010, 3'd3, 8'hA1, 0);
    endtask

    task automatic test_wrap();
        write_burst(11'h7FE, 3'd3, 8'h11);
        read_burst(11'h7FE, 3'd3, 8'h11, 0);
    endtask

    task automatic test_rd_stall();
        read_burst(11'h010, 3'd1, 8'hA1, 5);
    endtask

    task automatic test_reset_mid_burst();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 11'h100;
        bus.req_len   = 3'd7;
        tick();
        bus.req_valid = 1'b0;
        bus.wr_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_data = 8'hC0 + 8'(i);
            tick();
        end
        bus.wr_data = 8'hC3;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_rd_o_wr !== 1'b0 || bus.wr_ready !== 1'b0 || bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid wr/wr_ready/req_ready got=%b/%b/%b exp=0/0/0", mem_rd_o_wr, bus.wr_ready, bus.req_ready);
        end
        tick();
        rst = 1'b0;
        bus.wr_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_idle busy/req_ready got=%b/%b exp=0/1", bus.busy, bus.req_ready); end
        for (int i = 0; i < 8; i++) begin
            logic [AW-1:0] a;
            logic [7:0]    d;
            a = 11'h100 + 11'(i);
            d = (i < 3) ? 8'hC0 + 8'(i) : 8'h00;
            checks++; if (mem[a] !== d) begin errors++; $display("FAIL rst_mid_array[%h] got=%h exp=%h", a, mem[a], d); end
        end
        tick();
    endtask

    task automatic test_busy_req();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 11'h7FE;
        bus.req_len   = 3'd0;
        bus.rd_ready  = 1'b1;
        tick();
        bus.req_write = 1'b1;
        bus.req_addr  = 11'h300;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL busy_pulse_req_ready got=%b exp=0", bus.req_ready); end
        tick();
        bus.req_write = 1'b0;
        bus.req_addr  = 11'h7FF;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL busy_hold req_ready/busy got=%b/%b exp=0/1", bus.req_ready, bus.busy); end
        tick();
        @(negedge clk);
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h11) begin errors++; $display("FAIL busy_rd0 valid/data got=%b/%h exp=1/11", bus.rd_valid, bus.rd_data); end
        tick();
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL busy_first_idle busy/req_ready got=%b/%b exp=0/1", bus.busy, bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || mem_addr !== 11'h7FF) begin errors++; $display("FAIL busy_held_accept busy/addr got=%b/%h exp=1/7ff", bus.busy, mem_addr); end
        tick();
        tick();
        @(negedge clk);
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h12) begin errors++; $display("FAIL busy_rd1 valid/data got=%b/%h exp=1/12", bus.rd_valid, bus.rd_data); end
        tick();
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_end got=%b exp=0", bus.busy); end
        checks++; if (mem[11'h300] !== 8'h00) begin errors++; $display("FAIL busy_pulse_no_write got=%h exp=00", mem[11'h300]); end
        tick();
    endtask

    initial begin
        // NOTE: the array itself has no reset; the model is cleared once so untouched words read as 00.
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        test_reset();
        test_wr_rd_basic();
        test_wrap();
        test_rd_stall();
        test_reset_mid_burst();
        test_busy_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule : tb_array_access_ctrl

// File: doc/array_access_ctrl.md
ARRAY_ACCESS_CTRL -- requirements
Module: array_access_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word width in bits, equal to the attached array's WIDTH.
REQ-002 SHALL have parameter DEPTH, default 2048, word count (power of two), equal to the attached array's DEPTH; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter MAXBURST, default 8, max beats per request (power of two); LW = $clog2(MAXBURST).
REQ-004 One clock; reset is synchronous and active-high. Ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 req_valid in 1 / req_ready out 1: request handshake; fires when both are high at a clk edge.
REQ-006 req_write in 1 (1=write, 0=read); req_addr in AW, start word; req_len in LW, beats minus 1.
REQ-007 wr_valid in 1 / wr_ready out 1 / wr_data in WIDTH: write-data stream, one word per handshake.
REQ-008 rd_valid out 1 / rd_ready in 1 / rd_data out WIDTH: read-data stream, one word per handshake.
REQ-009 busy out 1: high whenever a burst is in progress.
REQ-010 mem_addr out AW, mem_rd_o_wr out 1 (0=read, 1=write), mem_i_data out WIDTH, mem_o_data in WIDTH: initiator side of the array port; mem_o_data is the registered read word, valid the cycle after the address is presented with mem_rd_o_wr=0.

Function
REQ-011 FSM states IDLE, WR, RD_ISSUE, RD_CAP, RD_HOLD.
REQ-012 IDLE: req_ready=1; on handshake latch cur_addr=req_addr, beats_left=req_len; go to WR if req_write, else RD_ISSUE; busy=0 only in IDLE.
REQ-013 WR: wr_ready=1; mem_rd_o_wr = wr_valid; mem_addr = cur_addr; mem_i_data = wr_data (combinational); each wr handshake writes one word, cur_addr increments, beats_left decrements; on the handshake with beats_left=0 go to IDLE. wr_valid low stalls indefinitely with no write issued.
REQ-014 RD_ISSUE: drive mem_addr=cur_addr, mem_rd_o_wr=0; next state RD_CAP unconditionally.
REQ-015 RD_CAP: register mem_o_data into rd_data, set rd_valid=1 at the closing edge; next state RD_HOLD.
REQ-016 RD_HOLD: rd_valid=1, rd_data stable until rd_ready; on handshake clear rd_valid, increment cur_addr; if beats_left=0 go to IDLE, else decrement beats_left and go to RD_ISSUE.
REQ-017 Read throughput is one word per 3 cycles with rd_ready held high; write throughput is one word per cycle with wr_valid held high.
REQ-018 cur_addr increments modulo DEPTH: DEPTH-1 wraps to 0 within a burst.
REQ-019 mem_rd_o_wr SHALL be 0 in every state except WR with wr_valid=1; wr_ready=0 outside WR; req_ready=0 outside IDLE.
REQ-020 Requests arriving while busy are not accepted (req_ready=0); requester holds them.

Reset
REQ-021 While rst=1 at a clk edge: state<=IDLE, rd_valid<=0, rd_data<=0, cur_addr<=0, beats_left<=0.
REQ-022 While rst=1, mem_rd_o_wr=0, req_ready=0, wr_ready=0 combinationally; no array write occurs during reset.
REQ-023 Reset mid-burst abandons remaining beats; words already written stay in the array; a pending rd_data word is discarded.

Structure
REQ-024 Shared package array_pkg holds the state enum type (arr_state_t) and default parameter constants (WIDTH, DEPTH, MAXBURST).
REQ-025 No sub-module; the block is a single FSM with datapath registers; the array module is instantiated beside it at top level, not inside it.

Verification (bench pairs the block with the array, WIDTH=8, DEPTH=2048, MAXBURST=8)
REQ-026 Write req addr=0x010 len=3, data 0xA1..0xA4, wr_valid high -> 4 consecutive writes at 0x010..0x013, back to IDLE 1 cycle after the last beat.
REQ-027 Read req addr=0x010 len=3, rd_ready high -> rd_data 0xA1,0xA2,0xA3,0xA4, rd_valid asserted every 3rd cycle, busy low after the last handshake.
REQ-028 Write addr=0x7FE len=3, data 0x11..0x14 -> words at 0x7FE,0x7FF,0x000,0x001; read-back returns the same.
REQ-029 Read with rd_ready low for 5 cycles on beat 0 -> rd_valid high, rd_data constant for all 5 cycles, no further mem_addr change until the handshake.
REQ-030 Write burst len=7, rst asserted after beat 2 -> mem_rd_o_wr=0 during reset, state IDLE, req_ready=1 the cycle after rst deasserts; only beats 0-2 present in the array.
REQ-031 req_valid pulsed while busy -> not accepted; held request accepted on the first IDLE cycle.
